// File: rtl/force_writeback_if.sv
// Force write-back bundle: requester heads from the force output buffers plus the
// single force-cache write port and drain status.
interface force_writeback_if #(
    parameter int NUM_FILTER  = 7,
    parameter int FORCE_WIDTH = 96,
    parameter int ADDR_WIDTH  = 9,
    parameter int SRC_WIDTH   = 3
);
    logic [NUM_FILTER-1:0]             output_force_valid;
    logic [NUM_FILTER*FORCE_WIDTH-1:0] force_in;
    logic [NUM_FILTER*ADDR_WIDTH-1:0]  force_addr_in;
    logic                              cache_ready;
    logic [NUM_FILTER-1:0]             write_success;
    logic                              cache_wr_en;
    logic [ADDR_WIDTH-1:0]             cache_wr_addr;
    logic [FORCE_WIDTH-1:0]            cache_wr_data;
    logic [SRC_WIDTH-1:0]              cache_wr_src;
    logic                              drained;

    // Arbiter side: consumes buffer heads, drives the cache write port.
    modport master (
        input  output_force_valid, force_in, force_addr_in, cache_ready,
        output write_success, cache_wr_en, cache_wr_addr, cache_wr_data,
        cache_wr_src, drained
    );

    // Buffer / cache side.
    modport slave (
        output output_force_valid, force_in, force_addr_in, cache_ready,
        input  write_success, cache_wr_en, cache_wr_addr, cache_wr_data,
        cache_wr_src, drained
    );
endinterface

// File: rtl/force_writeback_arbiter.sv
// Round-robin arbiter sharing the force-cache write port among the force output
// buffers, with a read-after-write hazard window over the cache accumulate pipeline.
module force_writeback_arbiter #(
    parameter int NUM_FILTER   = 7,
    parameter int FORCE_WIDTH  = 96,
    parameter int ADDR_WIDTH   = 9,
    parameter int HAZARD_DEPTH = 3,
    parameter int SRC_WIDTH    = 3
) (
    input  logic              clk,
    input  logic              rst,
    force_writeback_if.master bus
);

    logic [SRC_WIDTH-1:0]    rr_ptr;
    logic [HAZARD_DEPTH-1:0] haz_valid;
    logic [ADDR_WIDTH-1:0]   haz_addr [HAZARD_DEPTH];

    logic [NUM_FILTER-1:0]   hazard_hit;
    logic [NUM_FILTER-1:0]   eligible;
    logic [2*NUM_FILTER-1:0] doubled_shift;
    logic [NUM_FILTER-1:0]   rotated;
    logic                    found;
    logic [SRC_WIDTH-1:0]    winner;
    logic [SRC_WIDTH:0]      idx_sum;
    logic [SRC_WIDTH-1:0]    next_ptr;
    logic                    issue;
    logic                    drained_next;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [FORCE_WIDTH-1:0]  win_data;
    logic [NUM_FILTER-1:0]   win_onehot;

    // A requester is blocked while its address is still inside the accumulate pipeline.
    always_comb begin
        hazard_hit = '0;
        for (int i = 0; i < NUM_FILTER; i++) begin
            for (int d = 0; d < HAZARD_DEPTH; d++) begin
                if (haz_valid[d] &&
                    haz_addr[d] == bus.force_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH])
                    hazard_hit[i] = 1'b1;
            end
        end
    end

    assign eligible      = bus.output_force_valid & ~bus.write_success & ~hazard_hit;
    assign doubled_shift = {eligible, eligible} >> rr_ptr;
    assign rotated       = doubled_shift[NUM_FILTER-1:0];

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        idx_sum = '0;
        for (int k = 0; k < NUM_FILTER; k++) begin
            if (!found && rotated[k]) begin
                found   = 1'b1;
                idx_sum = {1'b0, rr_ptr} + (SRC_WIDTH+1)'(k);
                if (idx_sum >= (SRC_WIDTH+1)'(NUM_FILTER))
                    idx_sum = idx_sum - (SRC_WIDTH+1)'(NUM_FILTER);
                winner  = idx_sum[SRC_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        win_addr   = '0;
        win_data   = '0;
        win_onehot = '0;
        for (int i = 0; i < NUM_FILTER; i++) begin
            if (winner == SRC_WIDTH'(i)) begin
                win_addr      = bus.force_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_data      = bus.force_in[i*FORCE_WIDTH +: FORCE_WIDTH];
                win_onehot[i] = 1'b1;
            end
        end
    end

    assign issue        = found && bus.cache_ready;
    assign next_ptr     = (winner == SRC_WIDTH'(NUM_FILTER-1)) ? '0 : winner + SRC_WIDTH'(1);
    assign drained_next = (bus.output_force_valid == '0) && (haz_valid == '0) && !issue;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.write_success <= '0;
            bus.cache_wr_en   <= 1'b0;
            bus.cache_wr_addr <= '0;
            bus.cache_wr_data <= '0;
            bus.cache_wr_src  <= '0;
            bus.drained       <= 1'b1;
            rr_ptr            <= '0;
            haz_valid         <= '0;
        end else begin
            bus.drained  <= drained_next;
            haz_valid[0] <= issue;
            for (int d = 1; d < HAZARD_DEPTH; d++)
                haz_valid[d] <= haz_valid[d-1];
            if (issue) begin
                bus.cache_wr_en   <= 1'b1;
                bus.cache_wr_addr <= win_addr;
                bus.cache_wr_data <= win_data;
                bus.cache_wr_src  <= winner;
                bus.write_success <= win_onehot;
                rr_ptr            <= next_ptr;
            end else begin
                bus.cache_wr_en   <= 1'b0;
                bus.write_success <= '0;
            end
        end
    end

    // NOTE: hazard addresses are not reset; they are only ever qualified by haz_valid.
    always_ff @(posedge clk) begin
        haz_addr[0] <= win_addr;
        for (int d = 1; d < HAZARD_DEPTH; d++)
            haz_addr[d] <= haz_addr[d-1];
    end

endmodule

// File: tb/tb_force_writeback_arbiter.sv
// Directed bench for force_writeback_arbiter: a small buffer model pops a head on each
// write_success pulse; expected grants are hand-computed per cycle.
module tb_force_writeback_arbiter;

    localparam int NF = 7;
    localparam int FW = 96;
    localparam int AW = 9;
    localparam int HD = 3;
    localparam int SW = 3;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    int           remaining [NF];
    int           cnt       [NF];
    int           base      [NF];

    force_writeback_if #(.NUM_FILTER(NF), .FORCE_WIDTH(FW), .ADDR_WIDTH(AW), .SRC_WIDTH(SW)) bus ();

    force_writeback_arbiter #(
        .NUM_FILTER(NF), .FORCE_WIDTH(FW), .ADDR_WIDTH(AW),
        .HAZARD_DEPTH(HD), .SRC_WIDTH(SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] data_of(int i, int n);
        return {32'(i), 32'hF0C0_0000 + 32'(n), 32'(i * 100 + n)};
    endfunction

    function automatic logic [AW-1:0] addr_of(int i, int n);
        return AW'(base[i] + 16 * n);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NF; i++) begin
            bus.output_force_valid[i]         = (remaining[i] > 0);
            bus.force_in[i*FW +: FW]          = data_of(i, cnt[i]);
            bus.force_addr_in[i*AW +: AW]     = addr_of(i, cnt[i]);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NF; i++) begin
            if (bus.write_success[i]) begin
                cnt[i]++;
                remaining[i]--;
            end
        end
        drive();
    endtask

    task automatic clear_buffers();
        for (int i = 0; i < NF; i++) begin
            remaining[i] = 0;
            cnt[i]       = 0;
            base[i]      = i;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        bus.cache_ready = 1'b1;
        clear_buffers();
        drive();
        step();
    endtask

    logic [NF-1:0] exp_succ [10];

    initial begin
        rst = 1'b0;
        bus.cache_ready = 1'b0;
        clear_buffers();
        drive();

        // Reset with random inputs
        for (int r = 0; r < 2; r++) begin
            bus.output_force_valid = NF'($urandom);
            bus.force_addr_in      = {$urandom, $urandom, $urandom};
            bus.force_in           = {$urandom, $urandom, $urandom, $urandom, $urandom,
                                      $urandom, $urandom, $urandom, $urandom, $urandom,
                                      $urandom, $urandom, $urandom, $urandom, $urandom,
                                      $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            bus.cache_ready        = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst_success", bus.write_success, 0);
            check("rst_wr_en",   bus.cache_wr_en,   0);
            check("rst_addr",    bus.cache_wr_addr, 0);
            check("rst_data",    bus.cache_wr_data, 0);
            check("rst_src",     bus.cache_wr_src,  0);
            check("rst_drained", bus.drained,       1);
        end
        rst = 1'b1;
        bus.cache_ready = 1'b1;
        clear_buffers();
        drive();
        for (int c = 0; c < 3; c++) begin
            step();
            check("idle_drained", bus.drained, 1);
            check("idle_wr_en",   bus.cache_wr_en, 0);
        end

        // All seven valid, distinct addresses: one grant per cycle in index order
        apply_reset();
        for (int i = 0; i < NF; i++) remaining[i] = 1;
        rst = 1'b1;
        drive();
        for (int c = 1; c <= NF; c++) begin
            step();
            check("sweep_success", bus.write_success, 1 << (c - 1));
            check("sweep_wr_en",   bus.cache_wr_en, 1);
            check("sweep_addr",    bus.cache_wr_addr, c - 1);
            check("sweep_src",     bus.cache_wr_src, c - 1);
            check("sweep_data",    bus.cache_wr_data, data_of(c - 1, 0));
            check("sweep_drained", bus.drained, 0);
        end
        step(); step(); step();
        check("drain_hazard_tail", bus.drained, 0);
        step();
        check("drain_done", bus.drained, 1);

        // Address hazard: buffers 0 and 1 share addr 5, buffer 2 uses addr 9
        apply_reset();
        base[0] = 5; base[1] = 5; base[2] = 9;
        remaining[0] = 1; remaining[1] = 1; remaining[2] = 1;
        rst = 1'b1;
        drive();
        exp_succ[1] = 7'h01; exp_succ[2] = 7'h04; exp_succ[3] = 7'h00;
        exp_succ[4] = 7'h00; exp_succ[5] = 7'h02;
        for (int c = 1; c <= 5; c++) begin
            step();
            check("hazard_success", bus.write_success, exp_succ[c]);
        end
        check("hazard_late_addr", bus.cache_wr_addr, 5);
        check("hazard_late_src",  bus.cache_wr_src, 1);

        // Cache stall during cycles 3..6
        apply_reset();
        for (int i = 0; i < NF; i++) remaining[i] = 1000;
        rst = 1'b1;
        drive();
        exp_succ[1] = 7'h01; exp_succ[2] = 7'h02; exp_succ[3] = 7'h04;
        exp_succ[4] = 7'h00; exp_succ[5] = 7'h00; exp_succ[6] = 7'h00;
        exp_succ[7] = 7'h00; exp_succ[8] = 7'h08; exp_succ[9] = 7'h10;
        for (int c = 1; c <= 9; c++) begin
            step();
            check("stall_success", bus.write_success, exp_succ[c]);
            check("stall_wr_en",   bus.cache_wr_en, (exp_succ[c] != 0));
            if (c == 5) begin
                check("stall_src_hold",  bus.cache_wr_src, 2);
                check("stall_addr_hold", bus.cache_wr_addr, 2);
            end
            bus.cache_ready = !(c >= 3 && c <= 6);
        end

        // Single continuously valid buffer: lockout forces alternate-cycle grants
        apply_reset();
        remaining[3] = 1000;
        base[3] = 3;
        rst = 1'b1;
        drive();
        for (int c = 1; c <= 8; c++) begin
            step();
            check("lockout_success", bus.write_success, (c % 2 == 1) ? 7'h08 : 7'h00);
            check("lockout_drained", bus.drained, 0);
        end

        // Mid-burst reset: pointer returns to 0, lowest valid index wins next
        apply_reset();
        for (int i = 1; i < NF; i++) remaining[i] = 1000;
        rst = 1'b1;
        drive();
        for (int c = 1; c <= 3; c++) begin
            step();
            check("burst_success", bus.write_success, 1 << c);
        end
        rst = 1'b0;
        step();
        check("midrst_success", bus.write_success, 0);
        check("midrst_wr_en",   bus.cache_wr_en, 0);
        check("midrst_drained", bus.drained, 1);
        rst = 1'b1;
        step();
        check("postrst_success", bus.write_success, 7'h02);
        check("postrst_src",     bus.cache_wr_src, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
